uart_tx: RTL and testbench



---
 rtl/uart_tx_if.sv | 13 +
 rtl/uart_tx.sv | 159 +++++++++++++++
 tb/tb_uart_tx.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Byte-side handshake and serial pad signals of uart_tx, bundled for the controller and the transmitter.
`timescale 1ns/1ps
interface uart_tx_if;
    logic        init_i;
    logic [7:0]  data_i;
    logic [31:0] baud_div_i;
    logic        done_o;
    logic        busy_o;
    logic        data_o;

    modport master (output init_i, data_i, baud_div_i, input done_o, busy_o, data_o);
    modport slave  (input init_i, data_i, baud_div_i, output done_o, busy_o, data_o);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a runtime 32-bit baud divider (bit period = baud_div_i + 1 cycles).
// Define UART_TX_PARITY_EN to insert an even-parity bit between data bit 7 and the stop bit.
`timescale 1ns/1ps
module uart_tx (
    input  logic     clk_i,
    input  logic     rst_n_i,
    uart_tx_if.slave bus
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_PARITY = 3'd4
    } state_e;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;
`endif

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] div_q, div_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_sel_q, bit_sel_d;
    logic        line_q, line_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        tick;
`ifdef UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    // Compare against div_q itself so an all-ones divider never needs a 33-bit sum.
    assign tick = (state_q != S_IDLE) && (cnt_q == div_q);

    assign bus.data_o = line_q;
    assign bus.done_o = done_q;
    assign bus.busy_o = busy_q;

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // flop samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            shift_q   <= '0;
            bit_sel_q <= '0;
            line_q    <= 1'b1;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            shift_q   <= shift_d;
            bit_sel_q <= bit_sel_d;
            line_q    <= line_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // NOTE: every signal written here gets a default first; a missing default on any
    // path would infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        shift_d   = shift_q;
        bit_sel_d = bit_sel_q;
        line_d    = line_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        if (state_q != S_IDLE) begin
            cnt_d = tick ? '0 : cnt_q + 32'd1;
        end

        case (state_q)
            S_IDLE: begin
                line_d = 1'b1;
                if (bus.init_i) begin
                    state_d = S_START;
                    shift_d = bus.data_i;
                    div_d   = bus.baud_div_i;
                    cnt_d   = '0;
                    line_d  = 1'b0;
                    busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^bus.data_i;
`endif
                end
            end
            S_START: begin
                if (tick) begin
                    state_d   = S_DATA;
                    line_d    = shift_q[0];
                    bit_sel_d = '0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d   = shift_q >> 1;
                    bit_sel_d = bit_sel_q + 3'd1;
                    if (bit_sel_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        line_d  = parity_q;
`else
                        state_d = S_STOP;
                        line_d  = 1'b1;
`endif
                    end else begin
                        line_d = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    state_d = S_STOP;
                    line_d  = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                line_d  = 1'b1;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: vector table, directed corner sequences and random traffic
// checked cycle by cycle against a frame-level waveform model.
`timescale 1ns/1ps
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic clk_i = 1'b0;
    logic rst_n_i;

    uart_tx_if bus();

    uart_tx dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    // One expected line/busy/done triple per clock cycle; an empty queue means idle.
    typedef struct {
        logic line;
        logic busy;
        logic done;
        logic busy_chk;
    } exp_t;

    typedef struct {
        logic [7:0]  data;
        logic [31:0] div;
        logic [10:0] frame;
        int          done_at;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[4];
    int   n_vec = 0;
    int   n_err = 0;
    logic obs_line;
    logic obs_done;
    logic b2b_lines[0:63];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Expand one accepted byte into its per-cycle line waveform plus the done cycle.
    task automatic push_frame(input logic [7:0] d, input logic [31:0] div);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        bits.push_back(^d);
`endif
        bits.push_back(1'b1);
        foreach (bits[i]) begin
            for (int c = 0; c <= int'(div); c++) exp_q.push_back('{bits[i], 1'b1, 1'b0, 1'b1});
        end
        // busy in the handover (done) cycle is left unconstrained
        exp_q.push_back('{1'b1, 1'b0, 1'b1, 1'b0});
    endtask

    // One clock cycle: compare at the falling edge, update the model, return just after the rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk_i);
        if (!rst_n_i) exp_q.delete();
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = '{1'b1, 1'b0, 1'b0, 1'b1};
        obs_line = bus.data_o;
        obs_done = bus.done_o;
        check("line", bus.data_o, e.line);
        check("done", bus.done_o, e.done);
        if (e.busy_chk) check("busy", bus.busy_o, e.busy);
        if (rst_n_i && bus.init_i && exp_q.size() == 0) push_frame(bus.data_i, bus.baud_div_i);
        @(posedge clk_i);
        #1;
    endtask

    // Send one byte from idle, then decode the line like a receiver sampling mid-bit.
    task automatic send_decode(input string name, input logic [7:0] d, input logic [31:0] div,
                               input logic [10:0] frame, input int exp_done);
        logic       lines[0:255];
        logic [7:0] rx;
        int         done_at;
        int         dv;
        dv      = int'(div);
        done_at = -1;
        bus.data_i     = d;
        bus.baud_div_i = div;
        bus.init_i     = 1'b1;
        cycle();
        bus.init_i = 1'b0;
        for (int c = 1; c < 256; c++) begin
            cycle();
            lines[c] = obs_line;
            if (obs_done) begin
                done_at = c;
                break;
            end
        end
        check({name, "_done_at"}, done_at, exp_done);
        for (int i = 0; i < NBITS; i++) check({name, "_bit"}, lines[1 + i*(dv+1) + dv/2], frame[i]);
        for (int j = 0; j < 8; j++) rx[j] = lines[1 + (j+1)*(dv+1) + dv/2];
        check({name, "_rx_byte"}, rx, d);
    endtask

    initial begin
        #400us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done;

`ifdef UART_TX_PARITY_EN
        vecs[0] = '{8'hA5, 32'd3, 11'b1_0_1010_0101_0, 45};
        vecs[1] = '{8'h07, 32'd1, 11'b1_1_0000_0111_0, 23};
        vecs[2] = '{8'h03, 32'd1, 11'b1_0_0000_0011_0, 23};
        vecs[3] = '{8'hFF, 32'd0, 11'b1_0_1111_1111_0, 12};
`else
        vecs[0] = '{8'hA5, 32'd3, 11'b0_1_1010_0101_0, 41};
        vecs[1] = '{8'h00, 32'd0, 11'b0_1_0000_0000_0, 11};
        vecs[2] = '{8'hFF, 32'd1, 11'b0_1_1111_1111_0, 21};
        vecs[3] = '{8'h3C, 32'd2, 11'b0_1_0011_1100_0, 31};
`endif

        // Reset, then a long idle stretch
        rst_n_i        = 1'b0;
        bus.init_i     = 1'b0;
        bus.data_i     = 8'h00;
        bus.baud_div_i = 32'd0;
        repeat (5) cycle();
        rst_n_i = 1'b1;
        repeat (100) cycle();

        for (int v = 0; v < 4; v++) begin
            send_decode("table", vecs[v].data, vecs[v].div, vecs[v].frame, vecs[v].done_at);
            repeat (2) cycle();
        end

        // Back-to-back: second init_i in the done cycle of the first frame
        bus.baud_div_i = 32'd0;
        bus.data_i     = 8'h00;
        bus.init_i     = 1'b1;
        cycle();
        bus.init_i = 1'b0;
        for (int c = 1; c <= NBITS; c++) begin
            cycle();
            b2b_lines[c] = obs_line;
        end
        bus.init_i = 1'b1;
        bus.data_i = 8'hFF;
        cycle();
        check("b2b_first_done", obs_done, 1'b1);
        bus.init_i = 1'b0;
        for (int c = NBITS + 2; c <= 2*NBITS + 2; c++) begin
            cycle();
            b2b_lines[c] = obs_line;
        end
        check("b2b_first_stop", b2b_lines[NBITS], 1'b1);
        check("b2b_second_start", b2b_lines[NBITS + 2], 1'b0);
        check("b2b_second_bit0", b2b_lines[NBITS + 3], 1'b1);
        check("b2b_second_done", obs_done, 1'b1);
        repeat (3) cycle();

        // Busy ignore: a mid-frame init_i with new data and divider must change nothing
        bus.baud_div_i = 32'd7;
        bus.data_i     = 8'h3C;
        bus.init_i     = 1'b1;
        cycle();
        bus.init_i = 1'b0;
        repeat (30) cycle();
        bus.init_i     = 1'b1;
        bus.data_i     = 8'h81;
        bus.baud_div_i = 32'd1;
        cycle();
        bus.init_i = 1'b0;
        n_done = 0;
        repeat (120) begin
            cycle();
            if (obs_done) n_done++;
        end
        check("ignore_done_count", n_done, 1);

        // Reset in the middle of data bit 4 (0x86 has bit 4 low)
        bus.baud_div_i = 32'd2;
        bus.data_i     = 8'h86;
        bus.init_i     = 1'b1;
        cycle();
        bus.init_i = 1'b0;
        repeat (16) cycle();
        check("pre_reset_line", obs_line, 1'b0);
        rst_n_i = 1'b0;
        #1;
        check("reset_line", bus.data_o, 1'b1);
        check("reset_busy", bus.busy_o, 1'b0);
        check("reset_done", bus.done_o, 1'b0);
        cycle();
        rst_n_i = 1'b1;
        repeat (2) cycle();
`ifdef UART_TX_PARITY_EN
        send_decode("post_reset", 8'h55, 32'd1, 11'b1_0_0101_0101_0, 23);
`else
        send_decode("post_reset", 8'h55, 32'd1, 11'b0_1_0101_0101_0, 21);
`endif

        // Random traffic, including init_i pulses and divider changes while busy
        for (int it = 0; it < 400; it++) begin
            bus.data_i     = 8'($urandom);
            bus.baud_div_i = 32'($urandom_range(0, 3));
            bus.init_i     = ($urandom_range(0, 2) == 0);
            cycle();
            bus.init_i = 1'b0;
            repeat ($urandom_range(0, 12)) begin
                bus.baud_div_i = 32'($urandom_range(0, 3));
                bus.data_i     = 8'($urandom);
                cycle();
            end
        end
        for (int k = 0; k < 100 && exp_q.size() > 0; k++) cycle();
        repeat (3) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
